expense_ledger: RTL and testbench

EXPENSE_LEDGER -- requirements
Module: expense_ledger

---
 rtl/expense_ledger.sv | 194 +++++++++++++++++++
 tb/tb_expense_ledger.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/expense_ledger.sv
`default_nettype none
// ============================================================================
// Module      : expense_ledger
// Description : Two-person expense ledger with a latched budget and an
//               iteratively computed 90% threshold (floor(budget*9/10)).
//               Optional macro EXPENSE_LEDGER_SAT_EN clamps overflowing
//               accumulators to 16'hFFFF instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module expense_ledger (
    input  logic        clk,
    input  logic        rst,
    input  logic        budget_load,
    input  logic [15:0] budget_in,
    input  logic        clear,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic        exp_who,
    input  logic [15:0] exp_amount,
    output logic [15:0] budget,
    output logic [15:0] ninebudget,
    output logic        thresh_valid,
    output logic [15:0] prev_accum_a,
    output logic [15:0] prev_accum_b,
    output logic [7:0]  entry_count,
    output logic        overflow
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_CALC      = 2'd1;
    localparam logic [1:0] c_RUN       = 2'd2;
    localparam logic [4:0] c_CALC_LAST = 5'd16;
    localparam logic [4:0] c_DIVISOR   = 5'd10;

    logic [1:0]  r_state_q,   w_state_d;
    logic [4:0]  r_cnt_q,     w_cnt_d;
    logic [3:0]  r_rem_q,     w_rem_d;
    logic [15:0] r_quo_q,     w_quo_d;
    logic [15:0] r_budget_q,  w_budget_d;
    logic [15:0] r_nine_q,    w_nine_d;
    logic        r_thresh_q,  w_thresh_d;
    logic [15:0] r_acc_a_q,   w_acc_a_d;
    logic [15:0] r_acc_b_q,   w_acc_b_d;
    logic [7:0]  r_count_q,   w_count_d;
    logic        r_ovf_q,     w_ovf_d;

    logic        w_hs;
    logic [19:0] w_prod;
    logic [4:0]  w_trial;
    logic        w_ge;
    logic [3:0]  w_rem_next;
    logic [16:0] w_sum;
    logic [15:0] w_acc_res;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        if (budget_load) begin
            w_state_d = c_CALC;
        end else begin
            case (r_state_q)
                c_CALC:  if (r_cnt_q == c_CALC_LAST) w_state_d = c_RUN;
                default: w_state_d = r_state_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        exp_ready = (r_state_q == c_RUN) & ~clear & ~rst;
        w_hs      = exp_valid & exp_ready;
    end

    // Product 9*budget always has its top nibble below 10 (quotient < 2^16),
    // so the remainder is seeded with it and only 16 quotient bits remain.
    always_comb begin
        w_prod     = ({4'd0, budget_in} << 3) + {4'd0, budget_in};
        w_trial    = {r_rem_q, r_quo_q[15]};
        w_ge       = (w_trial >= c_DIVISOR);
        w_rem_next = w_ge ? 4'(w_trial - c_DIVISOR) : w_trial[3:0];
    end

    always_comb begin
        w_sum = {1'b0, (exp_who ? r_acc_b_q : r_acc_a_q)} + {1'b0, exp_amount};
`ifdef EXPENSE_LEDGER_SAT_EN
        w_acc_res = w_sum[16] ? 16'hFFFF : w_sum[15:0];
`else
        w_acc_res = w_sum[15:0];
`endif
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_d    = r_cnt_q;
        w_rem_d    = r_rem_q;
        w_quo_d    = r_quo_q;
        w_budget_d = r_budget_q;
        w_nine_d   = r_nine_q;
        w_thresh_d = r_thresh_q;
        w_acc_a_d  = r_acc_a_q;
        w_acc_b_d  = r_acc_b_q;
        w_count_d  = r_count_q;
        w_ovf_d    = r_ovf_q;

        if (budget_load) begin
            w_budget_d = budget_in;
            w_thresh_d = 1'b0;
            w_cnt_d    = 5'd0;
            w_rem_d    = w_prod[19:16];
            w_quo_d    = w_prod[15:0];
        end else if (r_state_q == c_CALC) begin
            if (r_cnt_q == c_CALC_LAST) begin
                w_nine_d   = r_quo_q;
                w_thresh_d = 1'b1;
            end else begin
                w_rem_d = w_rem_next;
                w_quo_d = {r_quo_q[14:0], w_ge};
                w_cnt_d = r_cnt_q + 5'd1;
            end
        end

        if (clear) begin
            w_acc_a_d = 16'd0;
            w_acc_b_d = 16'd0;
            w_count_d = 8'd0;
            w_ovf_d   = 1'b0;
        end else if (w_hs) begin
            if (exp_who) begin
                w_acc_b_d = w_acc_res;
            end else begin
                w_acc_a_d = w_acc_res;
            end
            if (w_sum[16]) begin
                w_ovf_d = 1'b1;
            end
            if (r_count_q != 8'hFF) begin
                w_count_d = r_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q    <= 5'd0;
            r_rem_q    <= 4'd0;
            r_quo_q    <= 16'd0;
            r_budget_q <= 16'd0;
            r_nine_q   <= 16'd0;
            r_thresh_q <= 1'b0;
            r_acc_a_q  <= 16'd0;
            r_acc_b_q  <= 16'd0;
            r_count_q  <= 8'd0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_cnt_q    <= w_cnt_d;
            r_rem_q    <= w_rem_d;
            r_quo_q    <= w_quo_d;
            r_budget_q <= w_budget_d;
            r_nine_q   <= w_nine_d;
            r_thresh_q <= w_thresh_d;
            r_acc_a_q  <= w_acc_a_d;
            r_acc_b_q  <= w_acc_b_d;
            r_count_q  <= w_count_d;
            r_ovf_q    <= w_ovf_d;
        end
    end

    assign budget       = r_budget_q;
    assign ninebudget   = r_nine_q;
    assign thresh_valid = r_thresh_q;
    assign prev_accum_a = r_acc_a_q;
    assign prev_accum_b = r_acc_b_q;
    assign entry_count  = r_count_q;
    assign overflow     = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_expense_ledger.sv
`default_nettype none
// ============================================================================
// Module      : tb_expense_ledger
// Description : Directed, table-driven bench for expense_ledger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_expense_ledger;

    logic        clk = 1'b0;
    logic        rst, budget_load, clear, exp_valid, exp_who;
    logic [15:0] budget_in, exp_amount;
    logic        exp_ready, thresh_valid, overflow;
    logic [15:0] budget, ninebudget, prev_accum_a, prev_accum_b;
    logic [7:0]  entry_count;

    always #5 clk = ~clk;

    expense_ledger dut (
        .clk          (clk),
        .rst          (rst),
        .budget_load  (budget_load),
        .budget_in    (budget_in),
        .clear        (clear),
        .exp_valid    (exp_valid),
        .exp_ready    (exp_ready),
        .exp_who      (exp_who),
        .exp_amount   (exp_amount),
        .budget       (budget),
        .ninebudget   (ninebudget),
        .thresh_valid (thresh_valid),
        .prev_accum_a (prev_accum_a),
        .prev_accum_b (prev_accum_b),
        .entry_count  (entry_count),
        .overflow     (overflow)
    );

`ifdef EXPENSE_LEDGER_SAT_EN
    localparam logic [15:0] c_A_OVF = 16'd65535;
`else
    localparam logic [15:0] c_A_OVF = 16'd464;
`endif

    typedef struct {
        logic [15:0] b;
        logic [15:0] nine;
    } bvec_t;

    typedef struct {
        logic        who;
        logic [15:0] amt;
        logic [15:0] a;
        logic [15:0] bb;
        logic [7:0]  cnt;
        logic        ovf;
    } evec_t;

    bvec_t bv[5];
    evec_t ev[7];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_budget(input logic [15:0] b, input logic [15:0] nine);
        int early;
        budget_load = 1'b1;
        budget_in   = b;
        step();
        budget_load = 1'b0;
        check("budget_latched", 32'(budget), 32'(b));
        check("thresh_cleared", 32'(thresh_valid), 0);
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (thresh_valid || exp_ready) early++;
        end
        check("calc_16_cycles", early, 0);
        step();
        check("thresh_edge17", 32'(thresh_valid), 1);
        check("ninebudget", 32'(ninebudget), 32'(nine));
        check("ready_in_run", 32'(exp_ready), 1);
    endtask

    initial begin
        bv[0] = '{16'd5000,  16'd4500};
        bv[1] = '{16'd65535, 16'd58981};
        bv[2] = '{16'd7,     16'd6};
        bv[3] = '{16'd0,     16'd0};
        bv[4] = '{16'd1000,  16'd900};

        ev[0] = '{1'b0, 16'd500,   16'd500,   16'd0,   8'd1, 1'b0};
        ev[1] = '{1'b1, 16'd400,   16'd500,   16'd400, 8'd2, 1'b0};
        ev[2] = '{1'b1, 16'd100,   16'd500,   16'd500, 8'd3, 1'b0};
        ev[3] = '{1'b0, 16'd64500, 16'd65000, 16'd500, 8'd4, 1'b0};
        ev[4] = '{1'b0, 16'd1000,  c_A_OVF,   16'd500, 8'd5, 1'b1};
        ev[5] = '{1'b1, 16'd0,     c_A_OVF,   16'd500, 8'd6, 1'b1};
        ev[6] = '{1'b0, 16'd0,     c_A_OVF,   16'd500, 8'd7, 1'b1};

        rst = 1'b1; budget_load = 1'b0; budget_in = '0; clear = 1'b0;
        exp_valid = 1'b0; exp_who = 1'b0; exp_amount = '0;
        step();
        step();
        check("rst_ready", 32'(exp_ready), 0);
        check("rst_budget", 32'(budget), 0);
        check("rst_nine", 32'(ninebudget), 0);
        check("rst_thresh", 32'(thresh_valid), 0);
        check("rst_count", 32'(entry_count), 0);

        // IDLE must refuse entries
        rst = 1'b0;
        exp_valid = 1'b1; exp_amount = 16'd9;
        #1;
        check("idle_ready", 32'(exp_ready), 0);
        step();
        exp_valid = 1'b0;
        check("idle_no_accept", 32'(entry_count), 0);
        check("idle_accum_a", 32'(prev_accum_a), 0);

        for (int i = 0; i < 5; i++) load_budget(bv[i].b, bv[i].nine);

        for (int i = 0; i < 7; i++) begin
            exp_valid = 1'b1; exp_who = ev[i].who; exp_amount = ev[i].amt;
            step();
            exp_valid = 1'b0;
            check("accum_a", 32'(prev_accum_a), 32'(ev[i].a));
            check("accum_b", 32'(prev_accum_b), 32'(ev[i].bb));
            check("count", 32'(entry_count), 32'(ev[i].cnt));
            check("overflow", 32'(overflow), 32'(ev[i].ovf));
        end

        // clear with an entry presented: entry dropped
        clear = 1'b1; exp_valid = 1'b1; exp_who = 1'b0; exp_amount = 16'd300;
        #1;
        check("clear_ready", 32'(exp_ready), 0);
        step();
        clear = 1'b0; exp_valid = 1'b0;
        check("clear_a", 32'(prev_accum_a), 0);
        check("clear_b", 32'(prev_accum_b), 0);
        check("clear_count", 32'(entry_count), 0);
        check("clear_ovf", 32'(overflow), 0);
        check("clear_keeps_budget", 32'(budget), 1000);

        // reload together with a handshake: entry accepted, CALC begins
        budget_load = 1'b1; budget_in = 16'd2000;
        exp_valid = 1'b1; exp_who = 1'b1; exp_amount = 16'd77;
        #1;
        check("reload_hs_ready", 32'(exp_ready), 1);
        step();
        budget_load = 1'b0;
        check("reload_hs_b", 32'(prev_accum_b), 77);
        check("reload_hs_count", 32'(entry_count), 1);
        check("reload_thresh", 32'(thresh_valid), 0);
        // held entry during CALC is not consumed
        for (int k = 0; k < 5; k++) step();
        check("hold_ready", 32'(exp_ready), 0);
        check("hold_b", 32'(prev_accum_b), 77);
        check("hold_count", 32'(entry_count), 1);
        exp_valid = 1'b0;
        // reload mid-CALC restarts the full count
        load_budget(16'd3000, 16'd2700);

        // clear and reload in the same cycle
        clear = 1'b1; budget_load = 1'b1; budget_in = 16'd10;
        step();
        clear = 1'b0; budget_load = 1'b0;
        check("clr_load_count", 32'(entry_count), 0);
        check("clr_load_b", 32'(prev_accum_b), 0);
        check("clr_load_budget", 32'(budget), 10);
        check("clr_load_thresh", 32'(thresh_valid), 0);
        for (int k = 0; k < 17; k++) step();
        check("clr_load_nine", 32'(ninebudget), 9);

        // entry_count saturates at 255
        exp_valid = 1'b1; exp_who = 1'b0; exp_amount = 16'd0;
        for (int k = 0; k < 260; k++) step();
        exp_valid = 1'b0;
        check("count_sat", 32'(entry_count), 255);

        // rst in the middle of CALC
        budget_load = 1'b1; budget_in = 16'd5000;
        step();
        budget_load = 1'b0;
        for (int k = 0; k < 8; k++) step();
        rst = 1'b1;
        step();
        check("midrst_ready", 32'(exp_ready), 0);
        rst = 1'b0;
        #1;
        check("midrst_budget", 32'(budget), 0);
        check("midrst_nine", 32'(ninebudget), 0);
        check("midrst_thresh", 32'(thresh_valid), 0);
        check("midrst_count", 32'(entry_count), 0);
        check("midrst_ready_idle", 32'(exp_ready), 0);
        for (int k = 0; k < 20; k++) step();
        check("midrst_no_partial", 32'(ninebudget), 0);
        load_budget(16'd1000, 16'd900);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
